// File: rtl/rpn_sequencer.sv
// Sequences a stack ALU from a stream of RPN tokens, tracking stack depth so that
// malformed expressions and overflows abort before the ALU sees a bad command.
module rpn_sequencer #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_data,
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_din,
  input  logic [N-1:0] alu_tos,
  input  logic         alu_ovf,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  input  logic         res_ready,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntTwo  = CntW'(2);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpPush = 3'b001;
  localparam logic [2:0] OpPop  = 3'b010;
  localparam logic [2:0] OpClr  = 3'b011;
  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;

  localparam logic [1:0] KindOperand = 2'b00;
  localparam logic [1:0] KindAdd     = 2'b01;
  localparam logic [1:0] KindMul     = 2'b10;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrUnder = 2'b01;
  localparam logic [1:0] ErrFull  = 2'b10;
  localparam logic [1:0] ErrOvf   = 2'b11;

  typedef enum logic [2:0] {StInit, StIdle, StWait, StResult, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tok_ready_q, tok_ready_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [N-1:0]    alu_din_q, alu_din_d;
  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            tok_fire;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = OpNop;
    alu_din_d   = alu_din_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    tok_fire    = tok_valid && tok_ready_q;

    unique case (state_q)
      StInit: begin
        alu_op_d = OpClr;
        cnt_d    = '0;
        state_d  = StIdle;
      end
      StIdle: begin
        if (tok_fire) begin
          case (tok_kind)
            KindOperand: begin
              if (cnt_q == CntFull) begin
                state_d    = StErr;
                err_d      = 1'b1;
                err_code_d = ErrFull;
              end else begin
                alu_op_d  = OpPush;
                alu_din_d = tok_data;
                cnt_d     = cnt_q + CntOne;
                state_d   = StWait;
              end
            end
            KindAdd, KindMul: begin
              if (cnt_q < CntTwo) begin
                state_d    = StErr;
                err_d      = 1'b1;
                err_code_d = ErrUnder;
              end else begin
                alu_op_d = (tok_kind == KindAdd) ? OpAdd : OpMul;
                cnt_d    = cnt_q - CntOne;
                state_d  = StWait;
              end
            end
            default: begin
              if (cnt_q != CntOne) begin
                state_d    = StErr;
                err_d      = 1'b1;
                err_code_d = ErrUnder;
              end else begin
                state_d     = StResult;
                res_valid_d = 1'b1;
                res_data_d  = alu_tos;
              end
            end
          endcase
        end
      end
      StWait: begin
        // The command issued from IDLE is still on alu_op here, so it tells us
        // whether alu_ovf refers to an arithmetic op.
        if ((alu_op_q == OpAdd || alu_op_q == OpMul) && alu_ovf) begin
          state_d    = StErr;
          err_d      = 1'b1;
          err_code_d = ErrOvf;
        end else begin
          state_d = StIdle;
        end
      end
      StResult: begin
        if (res_valid_q && res_ready) begin
          alu_op_d    = OpPop;
          cnt_d       = '0;
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StErr: begin
        if (tok_fire && tok_kind == 2'b11) begin
          alu_op_d   = OpClr;
          cnt_d      = '0;
          err_d      = 1'b0;
          err_code_d = ErrNone;
          state_d    = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    tok_ready_d = (state_d == StIdle) || (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      tok_ready_q <= 1'b0;
      alu_op_q    <= OpNop;
      alu_din_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tok_ready_q <= tok_ready_d;
      alu_op_q    <= alu_op_d;
      alu_din_q   <= alu_din_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign tok_ready = tok_ready_q;
  assign alu_op    = alu_op_q;
  assign alu_din   = alu_din_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: a stack ALU stub, directed and random RPN expressions,
// and a queue-based evaluator predicting results, error codes and ALU commands.
module tb_rpn_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [1:0]  tok_kind = 2'b00;
  logic [31:0] tok_data = '0;
  logic [2:0]  alu_op;
  logic [31:0] alu_din;
  logic [31:0] alu_tos;
  logic        alu_ovf;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready = 1'b0;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  rpn_sequencer #(.N(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .alu_op(alu_op), .alu_din(alu_din), .alu_tos(alu_tos), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Stack ALU stub: commands apply at the edge, overflow flag reflects the op on alu_op.
  logic signed [31:0] stk [0:15];
  int sp = 0;

  always @(posedge clk) begin
    case (alu_op)
      3'b001: if (sp < 16) begin stk[sp] <= alu_din; sp <= sp + 1; end
      3'b010: if (sp > 0) sp <= sp - 1;
      3'b011: sp <= 0;
      3'b100: if (sp >= 2) begin stk[sp-2] <= stk[sp-1] + stk[sp-2]; sp <= sp - 1; end
      3'b101: if (sp >= 2) begin stk[sp-2] <= stk[sp-1] * stk[sp-2]; sp <= sp - 1; end
      default: ;
    endcase
  end

  always_comb begin
    longint r;
    r       = 0;
    alu_ovf = 1'b0;
    alu_tos = (sp > 0) ? stk[sp-1] : 32'd0;
    if (sp >= 2 && (alu_op == 3'b100 || alu_op == 3'b101)) begin
      if (alu_op == 3'b100) r = longint'(stk[sp-1]) + longint'(stk[sp-2]);
      else                  r = longint'(stk[sp-1]) * longint'(stk[sp-2]);
      alu_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end
  end

  // Logs of issued ALU commands and of error codes at each rising edge of err.
  logic [2:0] ops_log [$];
  logic [1:0] err_log [$];
  logic       err_prev = 1'b0;

  always @(posedge clk) begin
    if (alu_op != 3'b000) ops_log.push_back(alu_op);
    if (err === 1'b1 && !err_prev) err_log.push_back(err_code);
    err_prev <= (err === 1'b1);
  end

  // Expression under test and predicted outcome.
  logic [1:0] tq_kind [$];
  int         tq_data [$];
  logic [2:0] exp_ops [$];
  bit         exp_err;
  logic [1:0] exp_code;
  int         exp_res;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic add_tok(input logic [1:0] k, input int d);
    tq_kind.push_back(k);
    tq_data.push_back(d);
  endtask

  task automatic set_err(input logic [1:0] code, inout bit in_err);
    exp_err  = 1'b1;
    exp_code = code;
    in_err   = 1'b1;
  endtask

  // Evaluates the token list as an RPN expression on a plain integer stack.
  task automatic build_model();
    int     st [$];
    bit     in_err;
    int     a, b;
    longint r;
    exp_ops.delete();
    exp_err = 0; exp_code = 2'b00; exp_res = 0; in_err = 0;
    for (int i = 0; i < tq_kind.size(); i++) begin
      if (in_err) begin
        if (tq_kind[i] == 2'b11) begin exp_ops.push_back(3'b011); in_err = 0; st.delete(); end
      end else begin
        case (tq_kind[i])
          2'b00: begin
            if (st.size() == 16) set_err(2'b10, in_err);
            else begin st.push_back(tq_data[i]); exp_ops.push_back(3'b001); end
          end
          2'b01, 2'b10: begin
            if (st.size() < 2) set_err(2'b01, in_err);
            else begin
              a = st.pop_back();
              b = st.pop_back();
              r = (tq_kind[i] == 2'b01) ? longint'(a) + longint'(b) : longint'(a) * longint'(b);
              exp_ops.push_back(tq_kind[i] == 2'b01 ? 3'b100 : 3'b101);
              if (r > 64'sd2147483647 || r < -64'sd2147483648) set_err(2'b11, in_err);
              else st.push_back(int'(r));
            end
          end
          default: begin
            if (st.size() != 1) set_err(2'b01, in_err);
            else begin exp_res = st[0]; st.delete(); exp_ops.push_back(3'b010); end
          end
        endcase
      end
    end
    if (in_err) begin
      tq_kind.push_back(2'b11);
      tq_data.push_back(0);
      exp_ops.push_back(3'b011);
    end
  endtask

  task automatic send_tok(input logic [1:0] k, input int d);
    int n;
    @(negedge clk);
    tok_valid = 1'b1; tok_kind = k; tok_data = d;
    n = 0;
    while (tok_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("tok_accept", tok_ready, 1);
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic run_expr(input int hold);
    int mark_ops, mark_err, n, mism;
    bit stable;
    build_model();
    mark_ops = ops_log.size();
    mark_err = err_log.size();
    for (int i = 0; i < tq_kind.size(); i++) send_tok(tq_kind[i], tq_data[i]);
    if (!exp_err) begin
      n = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("res_valid", res_valid, 1);
      chk("res_data", $signed(res_data), exp_res);
      stable = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!(res_valid === 1'b1 && $signed(res_data) === exp_res && tok_ready === 1'b0))
          stable = 0;
      end
      chk("res_hold", stable, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_drop", res_valid, 0);
    end else begin
      @(negedge clk);
      chk("err_code", (err_log.size() > mark_err) ? err_log[mark_err] : 2'b00, exp_code);
      chk("err_clear", {err, err_code}, 0);
    end
    repeat (2) @(negedge clk);
    chk("err_events", err_log.size() - mark_err, exp_err ? 1 : 0);
    chk("op_count", ops_log.size() - mark_ops, exp_ops.size());
    mism = 0;
    for (int i = 0; i < exp_ops.size() && mark_ops + i < ops_log.size(); i++)
      if (ops_log[mark_ops + i] !== exp_ops[i]) mism++;
    chk("op_seq", mism, 0);
    tq_kind.delete();
    tq_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {tok_ready, alu_op, res_valid, err, err_code}, 0);
    chk({tag, "_din"}, alu_din, 0);
    chk({tag, "_res"}, res_data, 0);
  endtask

  task automatic check_single_clr(input int mark);
    chk("init_clr_count", ops_log.size() - mark, 1);
    chk("init_clr_op", (ops_log.size() > mark) ? ops_log[mark] : 3'b000, 3'b011);
  endtask

  initial begin
    int mark, len, r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    mark = ops_log.size();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_single_clr(mark);

    // -3 -4 + -5 * = 35
    add_tok(0, -3); add_tok(0, -4); add_tok(1, 0); add_tok(0, -5); add_tok(2, 0); add_tok(3, 0);
    run_expr(0);
    // Signed overflow on ADD
    add_tok(0, 2147483647); add_tok(0, 1); add_tok(1, 0); add_tok(3, 0);
    run_expr(0);
    // Underflow on ADD; the following 7 and END are discarded until END clears
    add_tok(0, 5); add_tok(1, 0); add_tok(0, 7); add_tok(3, 0);
    run_expr(0);
    add_tok(0, 7); add_tok(3, 0);
    run_expr(0);
    // Seventeen operands overflow a 16-deep stack
    for (int i = 0; i < 17; i++) add_tok(0, 1);
    add_tok(3, 0);
    run_expr(0);
    // END with two entries is malformed
    add_tok(0, 1); add_tok(0, 2); add_tok(3, 0);
    run_expr(0);
    // Result held while the consumer stalls
    add_tok(0, 8); add_tok(0, -8); add_tok(2, 0); add_tok(3, 0);
    run_expr(5);

    // Reset mid-expression after three pushes
    send_tok(0, 1); send_tok(0, 2); send_tok(0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    mark = ops_log.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_single_clr(mark);
    add_tok(0, 1); add_tok(3, 0);
    run_expr(0);

    for (int e = 0; e < 40; e++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 5) begin
          if ($urandom_range(0, 3) == 0) add_tok(0, int'($urandom));
          else add_tok(0, $urandom_range(0, 40) - 20);
        end else if (r < 7) add_tok(1, 0);
        else if (r < 9) add_tok(2, 0);
        else break;
      end
      add_tok(3, 0);
      run_expr($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
